fifo_read_ctrl: RTL and testbench

- Read-side controller of the dual-clock asynchronous FIFO; runs entirely in the read clock domain.
- Owns the binary and Gray read pointers and drives the RAM read address.
- Compares its next Gray pointer with the write pointer already synchronized into the read domain to produce a registered empty flag, an almost-empty flag and a sticky underflow error.
- Its Gray pointer output goes to the read-to-write synchronizer, which feeds the write-side full logic.

---
 rtl/fifo_read_ctrl.sv | 92 +++++++++
 tb/tb_fifo_read_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the dual-clock FIFO: read pointers, empty/almost-empty and sticky underflow.
// Optional macro FIFO_RD_LEVEL_EN adds the registered r_level_o word-count output.
module fifo_read_ctrl #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                 r_clk_i,
    input  logic                 r_rst_i,
    input  logic                 r_en_i,
    input  logic [ADDR_SIZE:0]   rw_ptr_i,
    input  logic                 r_underflow_clr_i,
    output logic [ADDR_SIZE-1:0] r_addr_o,
    output logic [ADDR_SIZE:0]   r_ptr_o,
    output logic                 r_empty_o,
    output logic                 r_almost_empty_o,
    output logic                 r_underflow_o
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR_SIZE:0]   r_level_o
`endif
);

    localparam logic [ADDR_SIZE:0] AeThresh = (ADDR_SIZE+1)'(AE_THRESH);

    logic [ADDR_SIZE:0] r_bin_q, r_bin_d;
    logic [ADDR_SIZE:0] r_ptr_q, r_ptr_d;
    logic               r_empty_q, r_empty_d;
    logic               r_ae_q, r_ae_d;
    logic               r_uf_q, r_uf_d;
    logic               r_inc;
    logic               uf_set;
    logic [ADDR_SIZE:0] w_bin;
    logic [ADDR_SIZE:0] level_d;

`ifdef FIFO_RD_LEVEL_EN
    logic [ADDR_SIZE:0] r_level_q;
    assign r_level_o = r_level_q;
`else
    // Without the level port, level_d still feeds the almost-empty compare.
`endif

    // Gray-to-binary of the synchronized write pointer, MSB downwards.
    always_comb begin
        w_bin = '0;
        w_bin[ADDR_SIZE] = rw_ptr_i[ADDR_SIZE];
        for (int i = int'(ADDR_SIZE) - 1; i >= 0; i--) begin
            w_bin[i] = w_bin[i+1] ^ rw_ptr_i[i];
        end
    end

    always_comb begin
        r_inc     = r_en_i & ~r_empty_q;
        uf_set    = r_en_i & r_empty_q;
        r_bin_d   = r_bin_q + {{ADDR_SIZE{1'b0}}, r_inc};
        r_ptr_d   = (r_bin_d >> 1) ^ r_bin_d;
        level_d   = w_bin - r_bin_d;
        // Full-width compare: the wrap bit separates "full" from "empty".
        r_empty_d = (r_ptr_d == rw_ptr_i);
        r_ae_d    = (level_d <= AeThresh);
        // A fresh underflow beats a clear in the same cycle.
        r_uf_d    = uf_set | (r_uf_q & ~r_underflow_clr_i);
    end

    always_ff @(posedge r_clk_i or negedge r_rst_i) begin
        if (!r_rst_i) begin
            r_bin_q   <= '0;
            r_ptr_q   <= '0;
            r_empty_q <= 1'b1;
            r_ae_q    <= 1'b1;
            r_uf_q    <= 1'b0;
`ifdef FIFO_RD_LEVEL_EN
            r_level_q <= '0;
`endif
        end else begin
            r_bin_q   <= r_bin_d;
            r_ptr_q   <= r_ptr_d;
            r_empty_q <= r_empty_d;
            r_ae_q    <= r_ae_d;
            r_uf_q    <= r_uf_d;
`ifdef FIFO_RD_LEVEL_EN
            r_level_q <= level_d;
`endif
        end
    end

    assign r_addr_o         = r_bin_q[ADDR_SIZE-1:0];
    assign r_ptr_o          = r_ptr_q;
    assign r_empty_o        = r_empty_q;
    assign r_almost_empty_o = r_ae_q;
    assign r_underflow_o    = r_uf_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl (ADDR_SIZE=3, AE_THRESH=1) against a word-count model of the FIFO.
module tb_fifo_read_ctrl;

    logic       clk;
    logic       rstN;
    logic       rEn;
    logic [3:0] rwPtr;
    logic       ufClr;
    logic [2:0] rAddr;
    logic [3:0] rPtr;
    logic       rEmpty;
    logic       rAe;
    logic       rUf;
`ifdef FIFO_RD_LEVEL_EN
    logic [3:0] rLevel;
`endif

    int errors = 0;
    int checks = 0;

    // Model: counts of words written (as seen via rw_ptr_i) and read, mod 16
    int mWr, mRd, mLevel;
    bit mEmpty, mAe, mUf;

    fifo_read_ctrl #(.ADDR_SIZE(3), .AE_THRESH(1)) dut (
        .r_clk_i(clk),
        .r_rst_i(rstN),
        .r_en_i(rEn),
        .rw_ptr_i(rwPtr),
        .r_underflow_clr_i(ufClr),
        .r_addr_o(rAddr),
        .r_ptr_o(rPtr),
        .r_empty_o(rEmpty),
        .r_almost_empty_o(rAe),
        .r_underflow_o(rUf)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .r_level_o(rLevel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray(int v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic setWr(int v);
        mWr   = v % 16;
        rwPtr = gray(mWr);
    endtask

    task automatic modelReset();
        mRd = 0; mLevel = 0; mEmpty = 1; mAe = 1; mUf = 0;
    endtask

    // One clock edge; model follows the word-count rules, outputs sampled 1 ns later
    task automatic cycle();
        bit inc, ufSet;
        inc    = rEn && !mEmpty;
        ufSet  = rEn && mEmpty;
        mRd    = (mRd + (inc ? 1 : 0)) % 16;
        mLevel = (mWr - mRd + 16) % 16;
        mEmpty = (mLevel == 0);
        mAe    = (mLevel <= 1);
        mUf    = ufSet || (mUf && !ufClr);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        rEn = 1'b0;
        ufClr = 1'b0;
        setWr(0);
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; rEn = 1'b0; ufClr = 1'b0;
        setWr(0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        checks++; if (rEmpty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got=%b exp=1", rEmpty); end
        checks++; if (rAe !== 1'b1) begin errors++; $display("[TB] FAIL reset_ae got=%b exp=1", rAe); end
        checks++; if (rPtr !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ptr got=%b exp=0000", rPtr); end
        checks++; if (rAddr !== 3'd0) begin errors++; $display("[TB] FAIL reset_addr got=%0d exp=0", rAddr); end
        checks++; if (rUf !== 1'b0) begin errors++; $display("[TB] FAIL reset_uf got=%b exp=0", rUf); end
        cycle();
        checks++; if (rEmpty !== 1'b1) begin errors++; $display("[TB] FAIL idle_empty got=%b exp=1", rEmpty); end
    endtask

    task automatic test_directed_read();
        logic [2:0] expAddr [3];
        expAddr[0] = 3'd0; expAddr[1] = 3'd1; expAddr[2] = 3'd2;
        setWr(3);
        cycle();
        checks++; if (rEmpty !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty got=%b exp=0", rEmpty); end
        checks++; if (rAe !== 1'b0) begin errors++; $display("[TB] FAIL fill_ae got=%b exp=0", rAe); end
`ifdef FIFO_RD_LEVEL_EN
        checks++; if (rLevel !== 4'd3) begin errors++; $display("[TB] FAIL fill_level got=%0d exp=3", rLevel); end
`endif
        rEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rAddr !== expAddr[i]) begin errors++; $display("[TB] FAIL read_addr%0d got=%0d exp=%0d", i, rAddr, expAddr[i]); end
            cycle();
            checks++; if (rAe !== (i >= 1)) begin errors++; $display("[TB] FAIL read_ae%0d got=%b exp=%b", i, rAe, (i >= 1)); end
            checks++; if (rEmpty !== (i == 2)) begin errors++; $display("[TB] FAIL read_empty%0d got=%b exp=%b", i, rEmpty, (i == 2)); end
        end
        checks++; if (rPtr !== 4'b0010) begin errors++; $display("[TB] FAIL drained_ptr got=%b exp=0010", rPtr); end
    endtask

    task automatic test_underflow();
        rEn = 1'b1;
        cycle();
        checks++; if (rUf !== 1'b1) begin errors++; $display("[TB] FAIL uf_set got=%b exp=1", rUf); end
        checks++; if (rAddr !== 3'd3) begin errors++; $display("[TB] FAIL uf_addr got=%0d exp=3", rAddr); end
        checks++; if (rPtr !== 4'b0010) begin errors++; $display("[TB] FAIL uf_ptr got=%b exp=0010", rPtr); end
        ufClr = 1'b1;
        cycle();
        checks++; if (rUf !== 1'b1) begin errors++; $display("[TB] FAIL uf_set_wins got=%b exp=1", rUf); end
        rEn = 1'b0;
        cycle();
        checks++; if (rUf !== 1'b0) begin errors++; $display("[TB] FAIL uf_clear got=%b exp=0", rUf); end
        ufClr = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] prevPtr;
        doReset();
        setWr(2);
        cycle();
        rEn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            setWr(mRd + 2);
            prevPtr = rPtr;
            cycle();
            checks++; if ($countones(rPtr ^ prevPtr) != 1) begin errors++; $display("[TB] FAIL wrap_onebit%0d got=%b prev=%b exp one-bit change", i, rPtr, prevPtr); end
            checks++; if (rPtr !== gray(mRd)) begin errors++; $display("[TB] FAIL wrap_ptr%0d got=%b exp=%b", i, rPtr, gray(mRd)); end
            if (i == 8) begin
                checks++; if (rPtr !== 4'b1100) begin errors++; $display("[TB] FAIL wrap8_ptr got=%b exp=1100", rPtr); end
                checks++; if (rAddr !== 3'd0) begin errors++; $display("[TB] FAIL wrap8_addr got=%0d exp=0", rAddr); end
            end
            if (i == 16) begin
                checks++; if (rPtr !== 4'b0000) begin errors++; $display("[TB] FAIL wrap16_ptr got=%b exp=0000", rPtr); end
            end
        end
        rEn = 1'b0;
    endtask

    task automatic test_full();
        doReset();
        setWr(8);
        cycle();
        checks++; if (rEmpty !== 1'b0) begin errors++; $display("[TB] FAIL full_empty got=%b exp=0", rEmpty); end
        checks++; if (rAe !== 1'b0) begin errors++; $display("[TB] FAIL full_ae got=%b exp=0", rAe); end
`ifdef FIFO_RD_LEVEL_EN
        checks++; if (rLevel !== 4'd8) begin errors++; $display("[TB] FAIL full_level got=%0d exp=8", rLevel); end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rEn   = 1'($urandom_range(0, 1));
            ufClr = ($urandom_range(0, 3) == 0);
            if (((mWr - mRd + 16) % 16) < 8 && $urandom_range(0, 1) == 1) setWr(mWr + 1);
            cycle();
            checks++; if (rEmpty !== mEmpty) begin errors++; $display("[TB] FAIL rnd_empty n=%0d got=%b exp=%b", n, rEmpty, mEmpty); end
            checks++; if (rAe !== mAe) begin errors++; $display("[TB] FAIL rnd_ae n=%0d got=%b exp=%b", n, rAe, mAe); end
            checks++; if (rUf !== mUf) begin errors++; $display("[TB] FAIL rnd_uf n=%0d got=%b exp=%b", n, rUf, mUf); end
            checks++; if (rPtr !== gray(mRd)) begin errors++; $display("[TB] FAIL rnd_ptr n=%0d got=%b exp=%b", n, rPtr, gray(mRd)); end
            checks++; if (rAddr !== 3'(mRd)) begin errors++; $display("[TB] FAIL rnd_addr n=%0d got=%0d exp=%0d", n, rAddr, 3'(mRd)); end
`ifdef FIFO_RD_LEVEL_EN
            checks++; if (rLevel !== 4'(mLevel)) begin errors++; $display("[TB] FAIL rnd_level n=%0d got=%0d exp=%0d", n, rLevel, mLevel); end
`endif
        end
        rEn = 1'b0;
        ufClr = 1'b0;
    endtask

    task automatic test_async_reset();
        doReset();
        setWr(7);
        cycle();
        rEn = 1'b1;
        repeat (5) cycle();
        rEn = 1'b0;
        checks++; if (rAddr !== 3'd5) begin errors++; $display("[TB] FAIL pre_reset_addr got=%0d exp=5", rAddr); end
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (rAddr !== 3'd0) begin errors++; $display("[TB] FAIL async_addr got=%0d exp=0", rAddr); end
        checks++; if (rPtr !== 4'b0000) begin errors++; $display("[TB] FAIL async_ptr got=%b exp=0000", rPtr); end
        checks++; if (rEmpty !== 1'b1) begin errors++; $display("[TB] FAIL async_empty got=%b exp=1", rEmpty); end
        checks++; if (rAe !== 1'b1) begin errors++; $display("[TB] FAIL async_ae got=%b exp=1", rAe); end
        checks++; if (rUf !== 1'b0) begin errors++; $display("[TB] FAIL async_uf got=%b exp=0", rUf); end
`ifdef FIFO_RD_LEVEL_EN
        checks++; if (rLevel !== 4'd0) begin errors++; $display("[TB] FAIL async_level got=%0d exp=0", rLevel); end
`endif
        setWr(0);
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed_read();
        test_underflow();
        test_wrap();
        test_full();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
